// File: rtl/hetszegmens_pkg.sv
// Shared constants for the hetszegmens seven-segment encoder/receiver pair:
// segment bit positions, the hex<->pattern table and blank codes.
package hetszegmens_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam int unsigned AN_W  = 4;
    localparam int unsigned SEG_W = 8;
    localparam int unsigned PAT_W = 7;
    localparam int unsigned HEX_N = 16;

    localparam logic [AN_W-1:0]  AN_BLANK  = 4'hF;
    localparam logic [PAT_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low a..g pattern for each hex value; entry 0 is the rightmost.
    localparam logic [HEX_N-1:0][PAT_W-1:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [AN_W-1:0]  an;
        logic [SEG_W-1:0] seg;
    } scan_t;

endpackage

// File: rtl/hetszegmens_vevo_if.sv
// Multiplexed AN/SEG input bus plus decoded-digit results of the receiver.
interface hetszegmens_vevo_if;
    logic [3:0]  an_in;
    logic [7:0]  seg_in;
    logic        err_clr;
    logic [15:0] dout;
    logic [3:0]  dp_out;
    logic [3:0]  digit_vld;
    logic        frame_vld;
    logic        err;

    modport master (
        output an_in, seg_in, err_clr,
        input  dout, dp_out, digit_vld, frame_vld, err
    );

    modport slave (
        input  an_in, seg_in, err_clr,
        output dout, dp_out, digit_vld, frame_vld, err
    );
endinterface

// File: rtl/seg_minta_dekoder.sv
// Combinational lookup of an active-low 7-segment pattern back to its hex value.
module seg_minta_dekoder
    import hetszegmens_pkg::*;
(
    input  logic [PAT_W-1:0] pattern,
    output logic [3:0]       value_c,
    output logic             hit_c,
    output logic             blank_c
);

    always_comb begin
        value_c = '0;
        hit_c   = 1'b0;
        for (int i = 0; i < int'(HEX_N); i++) begin
            if (pattern == HEX_SEG[i]) begin
                value_c = 4'(i);
                hit_c   = 1'b1;
            end
        end
        blank_c = (pattern == SEG_BLANK);
    end

endmodule

// File: rtl/hetszegmens_vevo.sv
// Receive side of the 4-digit multiplexed seven-segment bus: settles, decodes, holds digits.
// Optional SEG_SYNC_EN adds a two-flop input synchronizer (reset to blank) ahead of the sampler.
module hetszegmens_vevo
    import hetszegmens_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4
)
(
    input  logic         clk,
    input  logic         rst,
    hetszegmens_vevo_if.slave bus
);

    localparam int unsigned CNT_W = 8;

    scan_t            samp_in_c;
    scan_t            samp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             primed_q;
    logic             strobe_c;

`ifdef SEG_SYNC_EN
    scan_t sync1_q;
    scan_t sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= '{an: bus.an_in, seg: bus.seg_in};
            sync2_q <= sync1_q;
        end
    end

    assign samp_in_c = sync2_q;
`else
    assign samp_in_c = '{an: bus.an_in, seg: bus.seg_in};
`endif

    // Sample register and saturating stability counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q   <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            samp_q   <= samp_in_c;
            primed_q <= 1'b1;
            if (samp_in_c != samp_q)
                cnt_q <= '0;
            else if (cnt_q != CNT_W'(SETTLE_CYC))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // primed_q keeps the cleared sample register from being captured straight out of reset.
    assign strobe_c = primed_q && (cnt_q == CNT_W'(SETTLE_CYC - 1));

    logic [3:0] dek_value_c;
    logic       dek_hit_c;
    logic       dek_blank_c;

    seg_minta_dekoder u_dekoder (
        .pattern (samp_q.seg[SEG_G:SEG_A]),
        .value_c (dek_value_c),
        .hit_c   (dek_hit_c),
        .blank_c (dek_blank_c)
    );

    logic [15:0] dout_q,  dout_nx_c;
    logic [3:0]  dp_q,    dp_nx_c;
    logic [3:0]  vld_q,   vld_nx_c;
    logic [3:0]  seen_q,  seen_nx_c;
    logic        frame_q, frame_c;
    logic        err_q,   err_set_c;

    // Capture-time classification of AN and SEG into next-state digit results.
    // A blank pattern with the decimal point lit is not a valid encoding and counts as an error.
    always_comb begin
        dout_nx_c = dout_q;
        dp_nx_c   = dp_q;
        vld_nx_c  = vld_q;
        seen_nx_c = seen_q;
        err_set_c = 1'b0;
        if (strobe_c && (samp_q.an != AN_BLANK)) begin
            if ($onehot(~samp_q.an)) begin
                for (int k = 0; k < 4; k++) begin
                    if (!samp_q.an[k]) begin
                        if (dek_hit_c) begin
                            dout_nx_c[4*k +: 4] = dek_value_c;
                            dp_nx_c[k]          = ~samp_q.seg[SEG_DP];
                            vld_nx_c[k]         = 1'b1;
                            seen_nx_c[k]        = 1'b1;
                        end else if (dek_blank_c && samp_q.seg[SEG_DP]) begin
                            vld_nx_c[k]  = 1'b0;
                            seen_nx_c[k] = 1'b1;
                        end else begin
                            err_set_c = 1'b1;
                        end
                    end
                end
            end else begin
                err_set_c = 1'b1;
            end
        end
        frame_c = (seen_nx_c == 4'hF);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q  <= '0;
            dp_q    <= '0;
            vld_q   <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dout_q  <= dout_nx_c;
            dp_q    <= dp_nx_c;
            vld_q   <= vld_nx_c;
            seen_q  <= frame_c ? 4'h0 : seen_nx_c;
            frame_q <= frame_c;
            err_q   <= err_set_c | (err_q & ~bus.err_clr);
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dp_out    = dp_q;
    assign bus.digit_vld = vld_q;
    assign bus.frame_vld = frame_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_hetszegmens_vevo.sv
// Scoreboard bench for hetszegmens_vevo: a transaction-level model predicts the held
// digit results after each stimulus hold; frame pulses are counted by a monitor.
module tb_hetszegmens_vevo;

    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hetszegmens_vevo_if bus ();

    hetszegmens_vevo #(.SETTLE_CYC(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] dout;
        logic [3:0]  dp;
        logic [3:0]  vld;
        logic        err;
        int          frames;
    } exp_t;

    exp_t sb[$];

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_total = 0;
    int n_bad   = 0;
    int frame_seen = 0;

    logic [15:0] m_dout;
    logic [3:0]  m_dp, m_vld, m_seen;
    logic        m_err;
    int          m_frames = 0;
    logic [11:0] last_val;
    bit          last_ok;
    int          run;

    always @(negedge clk) if (bus.frame_vld === 1'b1) frame_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dout = '0; m_dp = '0; m_vld = '0; m_seen = '0; m_err = 1'b0;
        last_ok = 1'b0; last_val = '0; run = 0;
    endtask

    // Predict the visible result of holding {an,seg} for 'cycles' edges.
    task automatic model_step(input logic [3:0] an, input logic [7:0] seg,
                              input int cycles, input int clr_edge);
        int rb, cap_edge, k;
        bit cap, cap_err, hit;
        logic [3:0] v, m;
        exp_t e;
        rb = (last_ok && last_val == {an, seg}) ? run : 0;
        run = rb + cycles;
        last_val = {an, seg};
        last_ok = 1'b1;
        cap = (rb < SETTLE + 1) && (run >= SETTLE + 1);
        cap_edge = SETTLE + 1 - rb;
        cap_err = 1'b0;
        if (cap && an != 4'hF) begin
            k = -1;
            for (int i = 0; i < 4; i++) begin
                m = 4'b0001 << i;
                if (an == ~m) k = i;
            end
            if (k < 0) cap_err = 1'b1;
            else begin
                hit = 1'b0; v = '0;
                for (int j = 0; j < 16; j++) if (seg[6:0] == tbl[j]) begin hit = 1'b1; v = 4'(j); end
                if (hit) begin
                    m_dout[4*k +: 4] = v; m_dp[k] = ~seg[7]; m_vld[k] = 1'b1; m_seen[k] = 1'b1;
                end else if (seg == 8'hFF) begin
                    m_vld[k] = 1'b0; m_seen[k] = 1'b1;
                end else cap_err = 1'b1;
            end
            if (m_seen == 4'hF) begin m_frames++; m_seen = '0; end
        end
        if (cap && cap_err) m_err = !(clr_edge > cap_edge);
        else if (clr_edge > 0) m_err = 1'b0;
        e.dout = m_dout; e.dp = m_dp; e.vld = m_vld; e.err = m_err; e.frames = m_frames;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_dout"},   32'(bus.dout),      32'(e.dout));
        chk({tag, "_dp"},     32'(bus.dp_out),    32'(e.dp));
        chk({tag, "_vld"},    32'(bus.digit_vld), 32'(e.vld));
        chk({tag, "_err"},    32'(bus.err),       32'(e.err));
        chk({tag, "_frames"}, 32'(frame_seen),    32'(e.frames));
    endtask

    // Inputs change #1 after an edge; edge e of the hold samples err_clr if e == clr_edge.
    task automatic drive(input string tag, input logic [3:0] an, input logic [7:0] seg,
                         input int cycles, input int clr_edge);
        model_step(an, seg, cycles, clr_edge);
        bus.an_in = an;
        bus.seg_in = seg;
        for (int e = 1; e <= cycles; e++) begin
            bus.err_clr = (e == clr_edge);
            @(posedge clk);
            #1;
        end
        bus.err_clr = 1'b0;
        compare(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, 32'(bus.dout),      32'd0);
        chk({tag, "_dp"},   32'(bus.dp_out),    32'd0);
        chk({tag, "_vld"},  32'(bus.digit_vld), 32'd0);
        chk({tag, "_frm"},  32'(bus.frame_vld), 32'd0);
        chk({tag, "_err"},  32'(bus.err),       32'd0);
    endtask

    logic [3:0] din [4] = '{4'h7, 4'h3, 4'h9, 4'hA};

    initial begin
        bus.an_in = 4'hF;
        bus.seg_in = 8'hFF;
        bus.err_clr = 1'b0;
        model_reset();
        #12;
        chk_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single digit: nothing visible after SETTLE edges, result on the next one.
        drive("d0_early", 4'hE, 8'hF8, SETTLE, 0);
        drive("d0_cap",   4'hE, 8'hF8, 6, 0);

        // Too-short hold then blank slot.
        drive("short",    4'hD, 8'hB0, 3, 0);
        drive("blank_an", 4'hF, 8'hFF, 6, 0);

        // Full scan 3,1,5(dp),8.
        drive("scan0", 4'hE, 8'hB0, 6, 0);
        drive("scan1", 4'hD, 8'hF9, 6, 0);
        drive("scan2", 4'hB, 8'h12, 6, 0);
        drive("scan3", 4'h7, 8'h80, 6, 0);

        // Illegal AN; err_clr coincident with the capture edge loses to the set.
        drive("bad_an",     4'hC, 8'hFF, SETTLE, 0);
        drive("bad_an_clr", 4'hC, 8'hFF, 3, 1);
        drive("legal",      4'hE, 8'hB0, 6, 0);
        drive("legal_clr",  4'hE, 8'hB0, 2, 1);

        // Blank digit keeps its value; blank with dp lit is undecodable.
        drive("blank_d1", 4'hD, 8'hFF, 6, 0);
        drive("bad_seg",  4'hD, 8'h7F, 6, 0);
        drive("clr",      4'hF, 8'hFF, 3, 2);
        drive("bad_pat",  4'hB, 8'hAA, 6, 0);
        drive("clr2",     4'hF, 8'hFF, 3, 1);

        for (int t = 0; t < 10; t++) begin
            int k, v, dp;
            logic [3:0] m;
            k = $urandom_range(0, 3);
            v = $urandom_range(0, 15);
            dp = $urandom_range(0, 1);
            m = 4'b0001 << k;
            drive("rnd", ~m, {~1'(dp), tbl[v]}, 6, 0);
        end

        // Loop-back style scan from an encoder image.
        for (int k = 0; k < 4; k++) begin
            logic [3:0] m;
            m = 4'b0001 << k;
            drive("loop", ~m, {1'b1, tbl[din[k]]}, 6, 0);
        end
        drive("loop_d0", 4'hE, {1'b1, tbl[din[0]]}, 6, 0);
        drive("loop_d1", 4'hD, {1'b1, tbl[din[1]]}, 6, 0);
        drive("loop_d2", 4'hB, {1'b1, tbl[din[2]]}, 2, 0);

        // Asynchronous reset mid-frame.
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] m;
            m = 4'b0001 << k;
            drive("recover", ~m, {1'b1, tbl[din[k]]}, 6, 0);
        end

        chk("recover_dout", 32'(bus.dout), 32'h0000A937);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
